// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package hazard_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned MD_CNT_W = 8;

   typedef logic [REG_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // Source-operand view of the instruction sitting in ID.
   typedef struct packed {
      reg_idx_t rs;
      reg_idx_t rt;
      logic     uses_rs;
      logic     uses_rt;
   } id_src_t;

   // True when a producer register feeds a live source operand of the ID instruction.
   function automatic logic reg_match(input reg_idx_t r, input id_src_t src);
      return (r != REG_ZERO) &&
             ((src.uses_rs && (r == src.rs)) || (src.uses_rt && (r == src.rt)));
   endfunction

endpackage

// File: rtl/md_busy_seq.sv
// Mult/div busy sequencer: md_busy is high for MD_LATENCY cycles after each start.
module md_busy_seq
   import hazard_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic md_start,
   output logic md_busy
);

   localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY);
   localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

   md_state_t             state;
   logic [MD_CNT_W-1:0]   cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (md_start) begin
                  state <= MD_BUSY;
                  cnt   <= CNT_LOAD;
               end
            end
            MD_BUSY: begin
               if (cnt == CNT_ONE) begin
                  // Back-to-back issue on the final busy cycle keeps the unit occupied.
                  if (md_start) begin
                     cnt <= CNT_LOAD;
                  end else begin
                     state <= MD_IDLE;
                     cnt   <= '0;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= MD_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (load-use, branch-after-load, mult/div busy).
// Optional performance counters enabled with `define HAZARD_PERF_EN.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 32,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] IF_ID_rs,
   input  logic [REG_W-1:0] IF_ID_rt,
   input  logic             IF_ID_uses_rs,
   input  logic             IF_ID_uses_rt,
   input  logic             IF_ID_is_branch,
   input  logic             IF_ID_is_md,
   input  logic             IF_ID_reads_hilo,
   input  logic [REG_W-1:0] ID_EX_rd,
   input  logic             ID_EX_MemRead,
   input  logic [REG_W-1:0] EX_MEM_rd,
   input  logic             EX_MEM_MemRead,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Flush,
   output logic             IF_ID_Flush,
   output logic             md_start,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   id_src_t id_src;
   logic    load_use;
   logic    br_haz;
   logic    md_haz;
   logic    stall;

   assign id_src = '{rs: IF_ID_rs, rt: IF_ID_rt, uses_rs: IF_ID_uses_rs, uses_rt: IF_ID_uses_rt};

   // ALU results are forwarded into ID; only loads in EX/MEM and a busy mult/div force a stall.
   assign load_use = ID_EX_MemRead && reg_match(ID_EX_rd, id_src);
   assign br_haz   = IF_ID_is_branch && EX_MEM_MemRead && reg_match(EX_MEM_rd, id_src);
   assign md_haz   = md_busy && (IF_ID_is_md || IF_ID_reads_hilo);
   assign stall    = load_use || br_haz || md_haz;

   // Reset holds the front end frozen and squashed; stall overrides any redirect.
   always_comb begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      IF_ID_Flush = 1'b1;
      md_start    = 1'b0;
      if (rst_n) begin
         if (stall) begin
            IF_ID_Flush = 1'b0;
         end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            ID_EX_Flush = 1'b0;
            IF_ID_Flush = (branch_taken && IF_ID_is_branch) || jump;
            md_start    = IF_ID_is_md;
         end
      end
   end

   md_busy_seq #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_busy_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .md_start (md_start),
      .md_busy  (md_busy)
   );

`ifdef HAZARD_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_ONE;
         end
         if (IF_ID_Flush && (flush_q != '1)) begin
            flush_q <= flush_q + CNT_ONE;
         end
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

   localparam int unsigned LAT   = 4;
   localparam int unsigned CW    = 4;
   localparam int          SAT   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    IF_ID_rs, IF_ID_rt, ID_EX_rd, EX_MEM_rd;
   logic          IF_ID_uses_rs, IF_ID_uses_rt, IF_ID_is_branch, IF_ID_is_md, IF_ID_reads_hilo;
   logic          ID_EX_MemRead, EX_MEM_MemRead, branch_taken, jump;
   logic          PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_start, md_busy;
   logic [CW-1:0] stall_cycles, flush_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference state: remaining busy cycles of the mult/div unit and event tallies.
   int m_left = 0;
   int m_sc   = 0;
   int m_fc   = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
      .IF_ID_uses_rs(IF_ID_uses_rs), .IF_ID_uses_rt(IF_ID_uses_rt),
      .IF_ID_is_branch(IF_ID_is_branch), .IF_ID_is_md(IF_ID_is_md),
      .IF_ID_reads_hilo(IF_ID_reads_hilo),
      .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
      .EX_MEM_rd(EX_MEM_rd), .EX_MEM_MemRead(EX_MEM_MemRead),
      .branch_taken(branch_taken), .jump(jump),
      .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Flush(ID_EX_Flush),
      .IF_ID_Flush(IF_ID_Flush), .md_start(md_start), .md_busy(md_busy),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   function automatic bit hits(input logic [4:0] r);
      return (r != 0) && ((IF_ID_uses_rs && r == IF_ID_rs) || (IF_ID_uses_rt && r == IF_ID_rt));
   endfunction

   // Expected {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_start, md_busy}.
   function automatic logic [5:0] exp_outs();
      bit busy, stl, fl;
      busy = (m_left > 0);
      if (!rst_n) return 6'b001100;
      stl = (ID_EX_MemRead && hits(ID_EX_rd)) ||
            (IF_ID_is_branch && EX_MEM_MemRead && hits(EX_MEM_rd)) ||
            (busy && (IF_ID_is_md || IF_ID_reads_hilo));
      if (stl) return {5'b00100, busy};
      fl = (branch_taken && IF_ID_is_branch) || jump;
      return {1'b1, 1'b1, 1'b0, fl, IF_ID_is_md, busy};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [5:0] e;
      if (!rst_n) begin
         m_left = 0; m_sc = 0; m_fc = 0;
      end else begin
         e = exp_outs();
         if (e[3]) m_sc = m_sc + 1;
         if (e[2]) m_fc = m_fc + 1;
         if (e[1]) m_left = LAT;
         else if (m_left > 0) m_left = m_left - 1;
      end
   end

   function automatic logic [5:0] dut_outs();
      return {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, md_start, md_busy};
   endfunction

   task automatic idle_inputs();
      IF_ID_rs = 0; IF_ID_rt = 0; IF_ID_uses_rs = 0; IF_ID_uses_rt = 0;
      IF_ID_is_branch = 0; IF_ID_is_md = 0; IF_ID_reads_hilo = 0;
      ID_EX_rd = 0; ID_EX_MemRead = 0; EX_MEM_rd = 0; EX_MEM_MemRead = 0;
      branch_taken = 0; jump = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [5:0] o;
      rst_n = 1'b0;
      idle_inputs();
      IF_ID_is_md = 1'b1; jump = 1'b0;
      #3;
      o = dut_outs(); n_cmp++;
      if (o !== 6'b001100) begin n_fail++; $display("FAIL reset_outs got=%b exp=001100", o); end
      n_cmp++;
      if (stall_cycles !== '0 || flush_count !== '0) begin
         n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
      end
      idle_inputs();
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      logic [5:0] o;
      idle_inputs();
      ID_EX_MemRead = 1; ID_EX_rd = 2; IF_ID_rs = 2; IF_ID_uses_rs = 1; IF_ID_rt = 4; IF_ID_uses_rt = 1;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b001000) begin n_fail++; $display("FAIL load_use_stall got=%b exp=001000", o); end
      next_cycle();
      ID_EX_MemRead = 0; ID_EX_rd = 0; EX_MEM_MemRead = 1; EX_MEM_rd = 2;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b110000) begin n_fail++; $display("FAIL load_use_release got=%b exp=110000", o); end
      next_cycle();
   endtask

   task automatic test_branch_after_load();
      logic [5:0] o;
      idle_inputs();
      IF_ID_is_branch = 1; branch_taken = 1; IF_ID_rs = 5; IF_ID_rt = 0;
      IF_ID_uses_rs = 1; IF_ID_uses_rt = 1; ID_EX_MemRead = 1; ID_EX_rd = 5;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b001000) begin n_fail++; $display("FAIL br_load_cyc1 got=%b exp=001000", o); end
      next_cycle();
      ID_EX_MemRead = 0; ID_EX_rd = 0; EX_MEM_MemRead = 1; EX_MEM_rd = 5;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b001000) begin n_fail++; $display("FAIL br_load_cyc2 got=%b exp=001000", o); end
      next_cycle();
      EX_MEM_MemRead = 0; EX_MEM_rd = 0;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b110100) begin n_fail++; $display("FAIL br_load_cyc3 got=%b exp=110100", o); end
      next_cycle();
   endtask

   task automatic test_zero_reg();
      logic [5:0] o;
      idle_inputs();
      ID_EX_MemRead = 1; ID_EX_rd = 0; IF_ID_rs = 0; IF_ID_uses_rs = 1;
      EX_MEM_MemRead = 1; EX_MEM_rd = 0; IF_ID_is_branch = 1;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b110000) begin n_fail++; $display("FAIL zero_reg got=%b exp=110000", o); end
      next_cycle();
   endtask

   task automatic test_md_busy();
      logic [5:0] o;
      logic [5:0] exp_seq [6];
      exp_seq = '{6'b110010, 6'b110001, 6'b001001, 6'b001001, 6'b001001, 6'b110000};
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
         IF_ID_is_md      = (c == 0);
         IF_ID_reads_hilo = (c >= 2);
         @(negedge clk); o = dut_outs(); n_cmp++;
         if (o !== exp_seq[c]) begin
            n_fail++; $display("FAIL md_seq_cyc%0d got=%b exp=%b", c, o, exp_seq[c]);
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_jump();
      logic [5:0] o;
      idle_inputs();
      jump = 1;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b110100) begin n_fail++; $display("FAIL jump_flush got=%b exp=110100", o); end
      next_cycle();
      ID_EX_MemRead = 1; ID_EX_rd = 7; IF_ID_rt = 7; IF_ID_uses_rt = 1;
      @(negedge clk); o = dut_outs(); n_cmp++;
      if (o !== 6'b001000) begin n_fail++; $display("FAIL jump_under_stall got=%b exp=001000", o); end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_reset_mid_md();
      logic [5:0] o;
      idle_inputs();
      IF_ID_is_md = 1;
      next_cycle();
      IF_ID_is_md = 0;
      next_cycle();
      rst_n = 1'b0;
      #1; o = dut_outs(); n_cmp++;
      if (o !== 6'b001100) begin n_fail++; $display("FAIL mid_md_reset got=%b exp=001100", o); end
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < LAT + 1; c++) begin
         @(negedge clk); n_cmp++;
         if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_aborted_cyc%0d got=%b exp=0", c, md_busy); end
         next_cycle();
      end
`ifdef HAZARD_PERF_EN
      n_cmp++;
      if (stall_cycles !== '0 || flush_count !== '0) begin
         n_fail++; $display("FAIL perf_after_reset got=%0d/%0d exp=0/0", stall_cycles, flush_count);
      end
      ID_EX_MemRead = 1; ID_EX_rd = 3; IF_ID_rs = 3; IF_ID_uses_rs = 1;
      next_cycle();
      idle_inputs();
      n_cmp++;
      if (stall_cycles !== CW'(1)) begin
         n_fail++; $display("FAIL perf_one_stall got=%0d exp=1", stall_cycles);
      end
`endif
   endtask

   task automatic test_random();
      logic [5:0] o, e;
      int exp_sc, exp_fc;
      for (int c = 0; c < 400; c++) begin
         IF_ID_rs         = 5'($urandom_range(0, 3));
         IF_ID_rt         = 5'($urandom_range(0, 3));
         IF_ID_uses_rs    = 1'($urandom_range(0, 1));
         IF_ID_uses_rt    = 1'($urandom_range(0, 1));
         IF_ID_is_branch  = ($urandom_range(0, 3) == 0);
         IF_ID_is_md      = ($urandom_range(0, 5) == 0);
         IF_ID_reads_hilo = ($urandom_range(0, 5) == 0);
         ID_EX_rd         = 5'($urandom_range(0, 3));
         ID_EX_MemRead    = ($urandom_range(0, 2) == 0);
         EX_MEM_rd        = 5'($urandom_range(0, 3));
         EX_MEM_MemRead   = ($urandom_range(0, 2) == 0);
         branch_taken     = 1'($urandom_range(0, 1));
         jump             = ($urandom_range(0, 6) == 0);
         @(negedge clk);
         o = dut_outs(); e = exp_outs(); n_cmp++;
         if (o !== e) begin n_fail++; $display("FAIL random_cyc%0d got=%b exp=%b", c, o, e); end
         next_cycle();
      end
      idle_inputs();
`ifdef HAZARD_PERF_EN
      exp_sc = (m_sc > SAT) ? SAT : m_sc;
      exp_fc = (m_fc > SAT) ? SAT : m_fc;
`else
      exp_sc = 0;
      exp_fc = 0;
`endif
      n_cmp++;
      if (stall_cycles !== CW'(exp_sc) || flush_count !== CW'(exp_fc)) begin
         n_fail++;
         $display("FAIL perf_random got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count, exp_sc, exp_fc);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_after_load();
      test_zero_reg();
      test_md_busy();
      test_jump();
      test_reset_mid_md();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
